// File: rtl/clock_pkg.sv
// Shared definitions for the clock/calendar controller.
// Holds field indices, bus widths, the controller FSM state type and the
// constant hour maximum reported to the counter bank.
package clock_pkg;

  localparam int unsigned N_FIELDS = 6;   // sec, min, hour, day, month, year
  localparam int unsigned N_DONE   = 5;   // year has no wrap pulse
  localparam int unsigned FIELD_W  = 3;

  localparam int unsigned SEC_W   = 6;
  localparam int unsigned MIN_W   = 6;
  localparam int unsigned HOUR_W  = 5;
  localparam int unsigned DAY_W   = 5;
  localparam int unsigned MONTH_W = 4;
  localparam int unsigned YEAR_W  = 7;

  localparam int unsigned F_SEC   = 0;
  localparam int unsigned F_MIN   = 1;
  localparam int unsigned F_HOUR  = 2;
  localparam int unsigned F_DAY   = 3;
  localparam int unsigned F_MONTH = 4;
  localparam int unsigned F_YEAR  = 5;

  localparam logic [HOUR_W-1:0]   HOUR_MAX = HOUR_W'(23);
  localparam logic [N_FIELDS-1:0] EN_ALL   = '1;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_EDIT,
    ST_CLAMP,
    ST_CLAMP_WAIT
  } state_t;

  // One-hot field mask from a field index.
  function automatic logic [N_FIELDS-1:0] field_onehot(input logic [FIELD_W-1:0] f);
    return N_FIELDS'(1) << f;
  endfunction

endpackage

// File: rtl/days_in_month.sv
// Combinational days-in-month lookup.
// Ports: month, year (counter-bank feedback) -> day_num.
// Build option: CLOCK_CTRL_LEAP_EN gives February 29 days when year[1:0] == 0
// (years 2000-2099); without it February always has 28 days.
module days_in_month
  import clock_pkg::*;
(
  input  logic [MONTH_W-1:0] month,
  input  logic [YEAR_W-1:0]  year,
  output logic [DAY_W-1:0]   day_num
);

  logic leap;

`ifdef CLOCK_CTRL_LEAP_EN
  // Every fourth year is a leap year within a single century.
  logic unused_year_hi;
  assign leap           = (year[1:0] == 2'b00);
  assign unused_year_hi = ^year[YEAR_W-1:2];
`else
  logic unused_year;
  assign leap        = 1'b0;
  assign unused_year = ^year;
`endif

  // Month length; out-of-range months fall back to 31.
  always_comb begin
    day_num = DAY_W'(31);
    case (month)
      MONTH_W'(2):  day_num = leap ? DAY_W'(29) : DAY_W'(28);
      MONTH_W'(4),
      MONTH_W'(6),
      MONTH_W'(9),
      MONTH_W'(11): day_num = DAY_W'(30);
      default:      day_num = DAY_W'(31);
    endcase
  end

endmodule

// File: rtl/clock_ctrl.sv
// Clock/calendar controller driving an external counter bank.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   tick_1hz                   one pulse per second
//   btn_mode/btn_up/btn_down   debounced one-cycle button pulses
//   second..year               counter-bank feedback
//   done_inc/done_dec          per-field wrap pulses from the bank
//   inc/dec/en                 registered step requests and enables
//   day_num, hour_num          field maxima for day and hour
//   edit_field                 0 = running, 1..6 = editing sec..year
// Build option: CLOCK_CTRL_LEAP_EN enables leap-year February (in days_in_month).
module clock_ctrl
  import clock_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                tick_1hz,
  input  logic                btn_mode,
  input  logic                btn_up,
  input  logic                btn_down,
  input  logic [SEC_W-1:0]    second,
  input  logic [MIN_W-1:0]    minute,
  input  logic [HOUR_W-1:0]   hour,
  input  logic [DAY_W-1:0]    day,
  input  logic [MONTH_W-1:0]  month,
  input  logic [YEAR_W-1:0]   year,
  input  logic [N_DONE-1:0]   done_inc,
  input  logic [N_DONE-1:0]   done_dec,
  output logic [N_FIELDS-1:0] inc,
  output logic [N_FIELDS-1:0] dec,
  output logic [N_FIELDS-1:0] en,
  output logic [DAY_W-1:0]    day_num,
  output logic [HOUR_W-1:0]   hour_num,
  output logic [FIELD_W-1:0]  edit_field
);

  state_t               state_q, state_d;
  state_t               ret_q, ret_d;
  logic [FIELD_W-1:0]   sel_q, sel_d;
  logic [1:0]           chk_q, chk_d;
  logic [N_FIELDS-1:0]  inc_d, dec_d, en_d;
  logic [FIELD_W-1:0]   edit_field_d;
  logic                 need_clamp;
  logic                 sel_is_cal;
  logic                 unused_fb;

  // Seconds/minutes/hours and borrow pulses never affect control decisions.
  assign unused_fb = ^{second, minute, hour, done_dec};

  days_in_month u_dim (
    .month   (month),
    .year    (year),
    .day_num (day_num)
  );

  assign hour_num   = HOUR_MAX;
  assign need_clamp = (day > day_num);
  assign sel_is_cal = (sel_q == FIELD_W'(F_MONTH)) || (sel_q == FIELD_W'(F_YEAR));

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      ret_q      <= ST_RUN;
      sel_q      <= '0;
      chk_q      <= '0;
      inc        <= '0;
      dec        <= '0;
      en         <= EN_ALL;
      edit_field <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      sel_q      <= sel_d;
      chk_q      <= chk_d;
      inc        <= inc_d;
      dec        <= dec_d;
      en         <= en_d;
      edit_field <= edit_field_d;
    end
  end

  // Next state and next registered outputs. chk_q is a two-stage delay so
  // that the day-validity test sees month/year feedback after the bank has
  // applied the step.
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    sel_d        = sel_q;
    chk_d        = {chk_q[0], 1'b0};
    inc_d        = '0;
    dec_d        = '0;
    en_d         = en;
    edit_field_d = edit_field;

    case (state_q)
      ST_RUN: begin
        if (chk_q[1] && need_clamp) begin
          state_d = ST_CLAMP;
          ret_d   = ST_RUN;
          chk_d   = '0;
        end else if (btn_mode) begin
          state_d = ST_EDIT;
          sel_d   = FIELD_W'(F_SEC);
        end else begin
          // Registered carry ripple: each wrap pulse steps the next field.
          inc_d = {done_inc, tick_1hz};
        end
      end

      ST_EDIT: begin
        if (chk_q[1] && need_clamp) begin
          state_d = ST_CLAMP;
          ret_d   = ST_EDIT;
          chk_d   = '0;
        end else if (btn_mode) begin
          if (sel_q == FIELD_W'(F_YEAR)) begin
            state_d  = ST_RUN;
            chk_d[0] = 1'b1;
          end else begin
            sel_d = sel_q + FIELD_W'(1);
          end
        end else if (btn_up ^ btn_down) begin
          inc_d    = btn_up   ? field_onehot(sel_q) : '0;
          dec_d    = btn_down ? field_onehot(sel_q) : '0;
          chk_d[0] = sel_is_cal;
        end
      end

      ST_CLAMP: begin
        state_d = ST_CLAMP_WAIT;
        chk_d   = '0;
      end

      ST_CLAMP_WAIT: begin
        chk_d   = '0;
        state_d = need_clamp ? ST_CLAMP : ret_q;
      end

      default: begin
        state_d = ST_RUN;
        chk_d   = '0;
      end
    endcase

    // Enables and field indicator follow the state being entered.
    case (state_d)
      ST_RUN: begin
        en_d         = EN_ALL;
        edit_field_d = '0;
      end
      ST_EDIT: begin
        en_d         = field_onehot(sel_d);
        edit_field_d = sel_d + FIELD_W'(1);
      end
      ST_CLAMP: begin
        en_d  = field_onehot(FIELD_W'(F_DAY));
        inc_d = '0;
        dec_d = field_onehot(FIELD_W'(F_DAY));
      end
      ST_CLAMP_WAIT: begin
        en_d  = field_onehot(FIELD_W'(F_DAY));
        inc_d = '0;
        dec_d = '0;
      end
      default: begin
        en_d = EN_ALL;
      end
    endcase
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// Bench for clock_ctrl: a behavioural counter bank feeds the controller,
// directed steps cover the listed scenarios, then a randomized section is
// compared against a calendar-arithmetic model.
module tb_clock_ctrl;

  logic       clk;
  logic       reset;
  logic       tick_1hz, btn_mode, btn_up, btn_down;
  logic [5:0] second, minute;
  logic [4:0] hour, day;
  logic [3:0] month;
  logic [6:0] year;
  logic [4:0] done_inc, done_dec;
  logic [5:0] inc, dec, en;
  logic [4:0] day_num, hour_num;
  logic [2:0] edit_field;

  int n_tests = 0;
  int n_fail  = 0;

  int bk[6];      // counter bank contents: sec, min, hour, day, month, year
  int ld[6];
  logic load;
  int m[6];       // reference calendar values
  int mode_exp;   // reference edit_field

  clock_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .tick_1hz   (tick_1hz),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .second     (second),
    .minute     (minute),
    .hour       (hour),
    .day        (day),
    .month      (month),
    .year       (year),
    .done_inc   (done_inc),
    .done_dec   (done_dec),
    .inc        (inc),
    .dec        (dec),
    .en         (en),
    .day_num    (day_num),
    .hour_num   (hour_num),
    .edit_field (edit_field)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dim(input int mo, input int y);
    if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
    if (mo == 2) begin
`ifdef CLOCK_CTRL_LEAP_EN
      return (y % 4 == 0) ? 29 : 28;
`else
      return (y < 0) ? 0 : 28;
`endif
    end
    return 31;
  endfunction

  function automatic int f_lo(input int i);
    return (i == 3 || i == 4) ? 1 : 0;
  endfunction

  function automatic int f_hi(input int i, input int mo, input int y);
    case (i)
      0, 1:    return 59;
      2:       return 23;
      3:       return dim(mo, y);
      4:       return 12;
      default: return 99;
    endcase
  endfunction

  assign second = 6'(bk[0]);
  assign minute = 6'(bk[1]);
  assign hour   = 5'(bk[2]);
  assign day    = 5'(bk[3]);
  assign month  = 4'(bk[4]);
  assign year   = 7'(bk[5]);

  // Bank wrap pulses are combinational on the step request.
  always_comb begin
    done_inc = '0;
    done_dec = '0;
    for (int i = 0; i < 5; i++) begin
      done_inc[i] = inc[i] && en[i] && (bk[i] >= f_hi(i, bk[4], bk[5]));
      done_dec[i] = dec[i] && en[i] && (bk[i] <= f_lo(i));
    end
  end

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 6; i++) bk[i] <= ld[i];
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (en[i] && inc[i] && !dec[i])
          bk[i] <= (bk[i] >= f_hi(i, bk[4], bk[5])) ? f_lo(i) : bk[i] + 1;
        else if (en[i] && dec[i] && !inc[i])
          bk[i] <= (bk[i] <= f_lo(i)) ? f_hi(i, bk[4], bk[5]) : bk[i] - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    check("inv_inc_dec_excl", 32'(inc & dec), 0);
    check("inv_req_needs_en", 32'((inc | dec) & ~en), 0);
  endtask

  task automatic press(input logic md, input logic up, input logic dn, input logic tk);
    btn_mode = md; btn_up = up; btn_down = dn; tick_1hz = tk;
    step();
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic load_date(input int s, input int mi, input int h,
                           input int d, input int mo, input int y);
    ld[0] = s; ld[1] = mi; ld[2] = h; ld[3] = d; ld[4] = mo; ld[5] = y;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 6; i++) m[i] = ld[i];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    mode_exp = 0;
  endtask

  // Model: one second forward with full calendar carry.
  task automatic advance_second();
    for (int i = 0; i < 6; i++) begin
      if (m[i] >= f_hi(i, m[4], m[5])) begin
        m[i] = f_lo(i);
      end else begin
        m[i] = m[i] + 1;
        break;
      end
    end
  endtask

  task automatic fix_day();
    if (m[3] > dim(m[4], m[5])) m[3] = dim(m[4], m[5]);
  endtask

  initial begin
    int cnt;
    int s0;
    bit seen;
    reset = 1'b1; load = 1'b0;
    tick_1hz = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    for (int i = 0; i < 6; i++) begin bk[i] = 1; ld[i] = 1; m[i] = 1; end
    mode_exp = 0;

    // Reset state
    do_reset();
    check("rst_inc", 32'(inc), 0);
    check("rst_dec", 32'(dec), 0);
    check("rst_en", 32'(en), 32'h3f);
    check("rst_edit_field", 32'(edit_field), 0);
    check("hour_num", 32'(hour_num), 23);

    // Month-length table, including out-of-range months
    for (int mo = 0; mo < 14; mo++) begin
      load_date(0, 0, 0, 1, mo, 8);
      check($sformatf("day_num_m%0d_y8", mo), 32'(day_num), 32'(dim(mo, 8)));
    end
    load_date(0, 0, 0, 1, 2, 8);
`ifdef CLOCK_CTRL_LEAP_EN
    check("feb_y08", 32'(day_num), 29);
`else
    check("feb_y08", 32'(day_num), 28);
`endif
    load_date(0, 0, 0, 1, 2, 9);
    check("feb_y09", 32'(day_num), 28);

    // Full ripple from a tick on 23:59:59 31/12/05
    load_date(59, 59, 23, 31, 12, 5);
    press(0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("ripple_inc%0d", i), 32'(inc), 32'(1 << i));
      step();
    end
    check("ripple_idle", 32'(inc), 0);
    check("ripple_sec", bk[0], 0);
    check("ripple_hour", bk[2], 0);
    check("ripple_day", bk[3], 1);
    check("ripple_month", bk[4], 1);
    check("ripple_year", bk[5], 6);

    // Mode sequence through every field back to RUN
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      press(1, 0, 0, 0);
      check($sformatf("mode_seq_%0d", k), 32'(edit_field), 32'(k % 7));
      check($sformatf("mode_en_%0d", k), 32'(en), (k % 7 == 0) ? 32'h3f : 32'(1 << (k - 1)));
      step();
      step();
    end

    // Minute edit: simultaneous up/down and a tick do nothing
    do_reset();
    load_date(10, 20, 5, 6, 7, 8);
    press(1, 0, 0, 0);
    press(1, 0, 0, 0);
    check("edit_min_field", 32'(edit_field), 2);
    press(0, 1, 1, 0);
    check("updown_inc", 32'(inc), 0);
    check("updown_dec", 32'(dec), 0);
    s0 = bk[0];
    press(0, 0, 0, 1);
    check("edit_tick_inc", 32'(inc), 0);
    step();
    check("edit_tick_sec", bk[0], s0);
    check("edit_tick_min", bk[1], 20);
    press(1, 1, 0, 0);
    check("mode_wins_inc", 32'(inc), 0);
    check("mode_wins_field", 32'(edit_field), 3);

    // Month down from 31 March: clamp the day to the end of February
    do_reset();
    load_date(0, 0, 12, 31, 3, 4);
    for (int k = 0; k < 5; k++) press(1, 0, 0, 0);
    check("clamp_edit_field", 32'(edit_field), 5);
    press(0, 0, 1, 0);
    check("clamp_month_dec", 32'(dec), 32'h10);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (dec[3]) cnt++;
    end
    check("clamp_pulses", cnt, 31 - dim(2, 4));
    check("clamp_day", bk[3], dim(2, 4));
    check("clamp_month", bk[4], 2);
    check("clamp_back_field", 32'(edit_field), 5);
    check("clamp_back_en", 32'(en), 32'h10);

    // Reset in the middle of a clamp discards it
    load_date(0, 0, 12, 31, 3, 4);
    press(0, 0, 1, 0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step();
      if (dec[3]) seen = 1'b1;
    end
    check("midclamp_seen", 32'(seen), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midclamp_rst_dec", 32'(dec), 0);
    check("midclamp_rst_field", 32'(edit_field), 0);
    check("midclamp_rst_en", 32'(en), 32'h3f);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (dec != 0) cnt++;
    end
    check("midclamp_no_more_dec", cnt, 0);

    // Reset one cycle into a ripple
    do_reset();
    load_date(59, 59, 23, 31, 12, 5);
    press(0, 0, 0, 1);
    check("midripple_inc0", 32'(inc), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midripple_inc", 32'(inc), 0);
    check("midripple_en", 32'(en), 32'h3f);
    check("midripple_field", 32'(edit_field), 0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (inc != 0) cnt++;
    end
    check("midripple_quiet", cnt, 0);
    check("midripple_min", bk[1], 59);

    // Randomized button/tick sequence against the calendar model
    do_reset();
    begin
      int mo0, y0;
      mo0 = $urandom_range(12, 1);
      y0  = $urandom_range(99);
      load_date($urandom_range(59), $urandom_range(59), $urandom_range(23),
                $urandom_range(dim(mo0, y0), 1), mo0, y0);
    end
    for (int it = 0; it < 80; it++) begin
      int op, f, e_inc, e_dec;
      op = $urandom_range(4);
      e_inc = 0;
      e_dec = 0;
      f = mode_exp - 1;
      case (op)
        0: begin
          if (mode_exp == 0) mode_exp = 1;
          else if (mode_exp == 6) begin mode_exp = 0; fix_day(); end
          else mode_exp++;
          press(1, 0, 0, 0);
        end
        1: begin
          if (mode_exp != 0) begin
            e_inc = 1 << f;
            m[f] = (m[f] >= f_hi(f, m[4], m[5])) ? f_lo(f) : m[f] + 1;
            if (f >= 4) fix_day();
          end
          press(0, 1, 0, 0);
        end
        2: begin
          if (mode_exp != 0) begin
            e_dec = 1 << f;
            m[f] = (m[f] <= f_lo(f)) ? f_hi(f, m[4], m[5]) : m[f] - 1;
            if (f >= 4) fix_day();
          end
          press(0, 0, 1, 0);
        end
        3: press(0, 1, 1, 0);
        default: begin
          if (mode_exp == 0) begin
            e_inc = 1;
            advance_second();
          end
          press(0, 0, 0, 1);
        end
      endcase
      check($sformatf("rnd%0d_op%0d_inc", it, op), 32'(inc), 32'(e_inc));
      check($sformatf("rnd%0d_op%0d_dec", it, op), 32'(dec), 32'(e_dec));
      for (int k = 0; k < 10; k++) step();
      for (int i = 0; i < 6; i++)
        check($sformatf("rnd%0d_field%0d", it, i), bk[i], m[i]);
      check($sformatf("rnd%0d_edit_field", it), 32'(edit_field), 32'(mode_exp));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
